// File: rtl/ahb2apb_req_arbiter.sv
// ahb2apb_req_arbiter: shares the AHB-to-APB bridge between NREQ single-word requesters
// by running one non-pipelined NONSEQ transfer at a time. Build option ARB_FIXED_PRIO_EN
// selects fixed priority (lowest index wins); the default build is round-robin.
module ahb2apb_req_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
    input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DATAWIDTH-1:0]      rsp_rdata,
    output logic                      rsp_err,
    output logic                      HSEL,
    output logic [ADDRWIDTH-1:0]      HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [3:0]                HPROT,
    output logic [DATAWIDTH-1:0]      HWDATA,
    input  logic                      HREADY,
    input  logic [DATAWIDTH-1:0]      HRDATA,
    input  logic                      HRESP,
    output logic                      arb_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [DATAWIDTH-1:0]  wdata_q, wdata_d;
    logic                  hsel_q, hsel_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [ADDRWIDTH-1:0]  haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [DATAWIDTH-1:0]  hwdata_q, hwdata_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  sel_found;
    logic [IW-1:0]         sel_idx;
    logic [IW:0]           scan_idx;
    logic                  sel_write;
    logic [ADDRWIDTH-1:0]  sel_addr;
    logic [DATAWIDTH-1:0]  sel_wdata;

    // Scan from ptr upward with wrap; in the fixed-priority build ptr never leaves 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IW+1)'(NREQ);
            end
            if (!sel_found && req_valid[scan_idx[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel_idx == IW'(k)) begin
                sel_write = req_write[k];
                sel_addr  = req_addr[k*ADDRWIDTH +: ADDRWIDTH];
                sel_wdata = req_wdata[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Gated by reset so no requester mistakes a reset cycle for an accept.
    assign req_ready = (state_q == IDLE && sel_found && !HRESET) ? (NREQ'(1) << sel_idx) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        wdata_d     = wdata_q;
        hsel_d      = hsel_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d  = ADDR;
                    gnt_d    = sel_idx;
                    wdata_d  = sel_wdata;
                    hsel_d   = 1'b1;
                    htrans_d = 2'b10;
                    haddr_d  = sel_addr;
                    hwrite_d = sel_write;
`ifndef ARB_FIXED_PRIO_EN
                    ptr_d    = (sel_idx == IW'(NREQ-1)) ? '0 : sel_idx + IW'(1);
`endif
                end
            end
            ADDR: begin
                if (HREADY) begin
                    state_d  = DATA;
                    hsel_d   = 1'b0;
                    htrans_d = 2'b00;
                    hwdata_d = wdata_q;
                end
            end
            DATA: begin
                if (HREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = NREQ'(1) << gnt_q;
                    rsp_err_d   = HRESP;
                    if (!hwrite_q) begin
                        rsp_rdata_d = HRDATA;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            wdata_q     <= '0;
            hsel_q      <= 1'b0;
            htrans_q    <= 2'b00;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            wdata_q     <= wdata_d;
            hsel_q      <= hsel_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign HSEL      = hsel_q;
    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HSIZE     = 3'b010;
    assign HPROT     = 4'b0011;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ahb2apb_req_arbiter.sv
// tb_ahb2apb_req_arbiter: directed plus randomized bench; requesters and bridge are modelled
// at transaction level (pending table, rotating priority index, per-transfer wait counts).
module tb_ahb2apb_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                 HCLK;
    logic                 HRESET;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 HSEL;
    logic [AW-1:0]        HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [3:0]           HPROT;
    logic [DW-1:0]        HWDATA;
    logic                 HREADY;
    logic [DW-1:0]        HRDATA;
    logic                 HRESP;
    logic                 arb_busy;

    ahb2apb_req_arbiter #(
        .NREQ(NREQ), .ADDRWIDTH(AW), .DATAWIDTH(DW)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
        .arb_busy(arb_busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int          checkCount = 0;
    int          failCount  = 0;
    logic        pend_v [NREQ];
    logic        pend_w [NREQ];
    logic [15:0] pend_a [NREQ];
    logic [31:0] pend_d [NREQ];
    int          model_ptr;
    int          clear_idx;
    logic [31:0] model_rdata;
    bit          randomMode;
    bit          keepAlive;
    int          rrOrder [5];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic setReq(input int i, input logic w, input logic [15:0] a, input logic [31:0] d);
        pend_v[i] = 1'b1;
        pend_w[i] = w;
        pend_a[i] = a;
        pend_d[i] = d;
    endtask

    task automatic newRandomReq(input int i);
        setReq(i, 1'($urandom_range(1)), 16'($urandom), $urandom);
    endtask

    task automatic driveRequesters();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]            = pend_v[i];
            req_write[i]            = pend_w[i];
            req_addr[i*AW +: AW]    = pend_a[i];
            req_wdata[i*DW +: DW]   = pend_d[i];
        end
    endtask

    // Requesters drop an accepted request the cycle after req_ready; random traffic may also
    // raise new requests or withdraw ones not yet granted.
    task automatic updateRequesters();
        if (clear_idx >= 0) begin
            pend_v[clear_idx] = 1'b0;
            if (keepAlive) newRandomReq(clear_idx);
            clear_idx = -1;
        end
        if (randomMode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i]) begin
                    if ($urandom_range(3) == 0) newRandomReq(i);
                end else if ($urandom_range(31) == 0) begin
                    pend_v[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic [31:0] rdat, input logic rerr);
        @(posedge HCLK);
        #1;
        updateRequesters();
        driveRequesters();
        HREADY = rdy;
        HRDATA = rdat;
        HRESP  = rerr;
        @(negedge HCLK);
    endtask

    function automatic int pickWinner();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (model_ptr + k) % NREQ;
            if (pend_v[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_hsel"},   32'(HSEL),      32'h0);
        checkOutput({tag, "_htrans"}, 32'(HTRANS),    32'h0);
        checkOutput({tag, "_haddr"},  32'(HADDR),     32'h0);
        checkOutput({tag, "_hwrite"}, 32'(HWRITE),    32'h0);
        checkOutput({tag, "_hwdata"}, HWDATA,         32'h0);
        checkOutput({tag, "_hsize"},  32'(HSIZE),     32'h2);
        checkOutput({tag, "_hprot"},  32'(HPROT),     32'h3);
        checkOutput({tag, "_rspv"},   32'(rsp_valid), 32'h0);
        checkOutput({tag, "_rdata"},  rsp_rdata,      32'h0);
        checkOutput({tag, "_err"},    32'(rsp_err),   32'h0);
        checkOutput({tag, "_busy"},   32'(arb_busy),  32'h0);
        checkOutput({tag, "_ready"},  32'(req_ready), 32'h0);
    endtask

    task automatic doReset(input string tag);
        @(posedge HCLK);
        #1;
        HRESET      = 1'b1;
        HREADY      = 1'b1;
        HRESP       = 1'b0;
        model_ptr   = 0;
        model_rdata = 32'h0;
        clear_idx   = -1;
        driveRequesters();
        @(negedge HCLK);
        checkResetValues(tag);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
    endtask

    // Entered at the sampling point of an IDLE cycle; returns at the sampling point of the
    // response cycle, which is itself the next arbitration cycle.
    task automatic runTransfer(input int wA, input int wD, input logic [31:0] rdv,
                               input logic rerr, output int g);
        logic [15:0] a;
        logic        w;
        logic [31:0] d;
        g = pickWinner();
        if (g < 0) begin
            checkOutput("idle_ready", 32'(req_ready), 32'h0);
            applyStimulus(1'b1, rdv, 1'b0);
            return;
        end
        checkOutput("grant", 32'(req_ready), 32'(4'(1) << g));
        checkOutput("busy_at_grant", 32'(arb_busy), 32'h0);
        a = pend_a[g];
        w = pend_w[g];
        d = pend_d[g];
        if (!FIXED) model_ptr = (g + 1) % NREQ;
        clear_idx = g;
        for (int c = 0; c <= wA; c++) begin
            applyStimulus(c == wA, rdv, 1'b0);
            checkOutput("addr_hsel",   32'(HSEL),      32'h1);
            checkOutput("addr_htrans", 32'(HTRANS),    32'h2);
            checkOutput("addr_haddr",  32'(HADDR),     32'(a));
            checkOutput("addr_hwrite", 32'(HWRITE),    32'(w));
            checkOutput("addr_busy",   32'(arb_busy),  32'h1);
            checkOutput("addr_ready",  32'(req_ready), 32'h0);
            checkOutput("addr_rspv",   32'(rsp_valid), 32'h0);
        end
        for (int c = 0; c <= wD; c++) begin
            applyStimulus(c == wD, rdv, rerr);
            checkOutput("data_hsel",   32'(HSEL),      32'h0);
            checkOutput("data_htrans", 32'(HTRANS),    32'h0);
            checkOutput("data_haddr",  32'(HADDR),     32'(a));
            checkOutput("data_hwdata", HWDATA,         d);
            checkOutput("data_busy",   32'(arb_busy),  32'h1);
            checkOutput("data_ready",  32'(req_ready), 32'h0);
            checkOutput("data_rspv",   32'(rsp_valid), 32'h0);
        end
        applyStimulus(1'b1, $urandom, 1'b0);
        if (!w) model_rdata = rdv;
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(4'(1) << g));
        checkOutput("rsp_err",   32'(rsp_err),   32'(rerr));
        checkOutput("rsp_rdata", rsp_rdata,      model_rdata);
        checkOutput("rsp_busy",  32'(arb_busy),  32'h0);
    endtask

    task automatic drain();
        int g;
        for (int k = 0; k < 2*NREQ; k++) begin
            if (pickWinner() < 0) break;
            runTransfer(0, 0, $urandom, 1'b0, g);
        end
    endtask

    initial begin
        int g;
        rrOrder    = '{0, 1, 2, 3, 0};
        HRESET     = 1'b1;
        HREADY     = 1'b1;
        HRDATA     = '0;
        HRESP      = 1'b0;
        randomMode = 1'b0;
        keepAlive  = 1'b0;
        clear_idx  = -1;
        for (int i = 0; i < NREQ; i++) begin
            pend_v[i] = 1'b0; pend_w[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0;
        end
        driveRequesters();
        doReset("rst0");

        $display("[TB] single zero-wait write from requester 1");
        setReq(1, 1'b1, 16'h0040, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("t1_ready", 32'(req_ready), 32'h2);
        runTransfer(0, 0, 32'h0, 1'b0, g);
        checkOutput("t1_rspv", 32'(rsp_valid), 32'h2);

        $display("[TB] read with three data-phase wait states");
        setReq(0, 1'b0, 16'h0100, 32'h0);
        applyStimulus(1'b1, 32'h0, 1'b0);
        runTransfer(0, 3, 32'h12345678, 1'b0, g);
        checkOutput("t2_rdata", rsp_rdata, 32'h12345678);

        $display("[TB] error response on requester 2, then a clean transfer");
        setReq(2, 1'b0, 16'h0200, 32'h0);
        applyStimulus(1'b1, 32'h0, 1'b0);
        runTransfer(0, 0, 32'hCAFE0002, 1'b1, g);
        checkOutput("t3_rspv", 32'(rsp_valid), 32'h4);
        checkOutput("t3_err", 32'(rsp_err), 32'h1);
        setReq(2, 1'b0, 16'h0204, 32'h0);
        applyStimulus(1'b1, 32'h0, 1'b0);
        runTransfer(1, 1, 32'h0BADF00D, 1'b0, g);
        checkOutput("t3_err_clear", 32'(rsp_err), 32'h0);

        $display("[TB] randomized traffic");
        randomMode = 1'b1;
        for (int t = 0; t < 60; t++) begin
            runTransfer(int'($urandom_range(2)), int'($urandom_range(2)), $urandom,
                        1'($urandom_range(3) == 0), g);
        end
        randomMode = 1'b0;
        drain();

        $display("[TB] all requesters valid continuously from reset");
        for (int i = 0; i < NREQ; i++) newRandomReq(i);
        keepAlive = 1'b1;
        doReset("rst1");
        for (int k = 0; k < 5; k++) begin
            checkOutput("t4_order", 32'(req_ready), 32'(4'(1) << (FIXED ? 0 : rrOrder[k])));
            runTransfer(0, 0, $urandom, 1'b0, g);
        end
        keepAlive = 1'b0;
        drain();

        $display("[TB] reset during a stalled data phase");
        setReq(1, 1'b0, 16'h0300, 32'h55AA55AA);
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("mr_grant", 32'(req_ready), 32'h2);
        if (!FIXED) model_ptr = 2;
        clear_idx = 1;
        applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0);
        checkOutput("mr_addr_hsel", 32'(HSEL), 32'h1);
        setReq(0, 1'b1, 16'h0400, 32'h11111111);
        setReq(2, 1'b1, 16'h0408, 32'h22222222);
        setReq(3, 1'b1, 16'h040C, 32'h33333333);
        applyStimulus(1'b0, 32'hFFFFFFFF, 1'b0);
        checkOutput("mr_data_busy", 32'(arb_busy), 32'h1);
        checkOutput("mr_data_hsel", 32'(HSEL), 32'h0);
        #2;
        HRESET      = 1'b1;
        model_ptr   = 0;
        model_rdata = 32'h0;
        #1;
        checkResetValues("mr_async");
        @(posedge HCLK);
        #1;
        HREADY = 1'b1;
        @(negedge HCLK);
        checkOutput("mr_no_rsp", 32'(rsp_valid), 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("mr_first_grant", 32'(req_ready), 32'h1);
        runTransfer(0, 0, 32'h13572468, 1'b0, g);
        drain();

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ahb2apb_req_arbiter.md
# ahb2apb_req_arbiter

Round-robin arbiter and AHB-Lite master sequencer that shares the AHB-to-APB bridge between NREQ simple requesters. Each requester presents a single-word read or write. The block grants one requester at a time and runs a non-pipelined NONSEQ transfer on the bridge's AHB slave port. It then returns read data and error status to the granted requester. It sits between on-chip control agents (DMA descriptors, debug, CPU side-port) and the bridge.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDRWIDTH, 16, address width, matches bridge
- DATAWIDTH, 32, data width, matches bridge

Ports:
- HCLK  in  1  clock, shared with the bridge
- HRESET  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDRWIDTH  packed addresses, requester i at [i*ADDRWIDTH +: ADDRWIDTH]
- req_wdata  in  NREQ*DATAWIDTH  packed write data
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot completion pulse
- rsp_rdata  out  DATAWIDTH  read data, shared, qualified by rsp_valid
- rsp_err  out  1  HRESP of completed transfer, qualified by rsp_valid
- HSEL  out  1  bridge select
- HADDR  out  ADDRWIDTH  address
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
- HWRITE  out  1  direction
- HSIZE  out  3  constant 3'b010
- HPROT  out  4  constant 4'b0011
- HWDATA  out  DATAWIDTH  write data
- HREADY  in  1  bridge HREADYOUT; also looped back to bridge HREADYIN externally
- HRDATA  in  DATAWIDTH  read data
- HRESP  in  1  error response
- arb_busy  out  1  high when state != IDLE

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid, pick grant g.
  - Drive req_ready[g]=1 combinationally in the same cycle.
  - Latch req_write/addr/wdata of g and the index g.
  - Go to ADDR.
- ADDR:
  - HSEL=1, HTRANS=NONSEQ, HADDR/HWRITE from latch.
  - Stay while HREADY=0.
  - On HREADY=1, go to DATA.
- DATA:
  - HSEL=0, HTRANS=IDLE, HWDATA = latched wdata; HADDR holds its value.
  - Stay while HREADY=0.
  - On HREADY=1, register HRDATA into rsp_rdata (reads only; writes leave it unchanged) and HRESP into rsp_err.
  - Pulse rsp_valid[g] for one cycle, then go to IDLE.
- Round-robin:
  - ptr holds the highest-priority index; search runs ptr, ptr+1, ... mod NREQ.
  - On grant, ptr <= (g+1) mod NREQ.
- req_ready is only asserted in IDLE. Requesters hold req_* stable until they see req_ready.
- Deasserting req_valid before grant is legal; that requester is not served.
- A requester that re-requests immediately after rsp_valid competes normally and does not keep priority.
- Simultaneous rsp_valid pulse and new grant in the same IDLE cycle is legal and required.
- Reset values:
  - All outputs 0 except HSIZE=3'b010, HPROT=4'b0011.
  - State IDLE, ptr 0.
- Reset mid-transfer: return to IDLE at once, without completing the transfer or pulsing rsp_valid. The bridge is reset by its own HRESETn; system integration asserts both together.

## Timing
- Zero-wait transfer, request seen in IDLE at cycle 0:
  - Cycle 0: req_ready.
  - Cycle 1: ADDR.
  - Cycle 2: DATA.
  - Cycle 3: rsp_valid, back in IDLE.
- Sustained throughput for zero-wait transfers: one transfer per 3 cycles.
- Each HREADY=0 cycle in ADDR or DATA adds exactly one cycle of latency.
- Outputs HSEL/HTRANS/HADDR/HWRITE/HWDATA/rsp_* are registered; req_ready is combinational from req_valid, state and ptr.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins; ptr is not implemented and stays 0.
  - Undefined (default): round-robin as above.

## Test plan
- Single write, zero wait:
  - Stimulus: req 1, addr 0x0040, wdata 0xDEADBEEF.
  - Response: req_ready[1] at cycle 0; HTRANS=2'b10, HADDR=0x0040, HWRITE=1 at cycle 1; HWDATA=0xDEADBEEF at cycle 2; rsp_valid=4'b0010, rsp_err=0 at cycle 3.
- Read with 3 HREADY=0 cycles in DATA:
  - Stimulus: HRDATA=0x12345678.
  - Response: rsp_valid at cycle 6, rsp_rdata=0x12345678.
- All four requesters valid continuously from reset:
  - Response (round-robin build): grants in order 0,1,2,3,0, one every 3 cycles.
  - Response (ARB_FIXED_PRIO_EN): requester 0 is granted every time.
- HRESP=1 on a read to requester 2:
  - Response: rsp_valid=4'b0100, rsp_err=1; the next transfer reports rsp_err=0.
- Reset mid-transfer:
  - Stimulus: HRESET asserted while in DATA with HREADY=0.
  - Response: all outputs return to reset values; no rsp_valid pulse; after release, requester 0 is granted first.
